// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage registers: NOP encoding, per-stage
// payload widths and control-field bit offsets inside each payload.
// No logic; imported by pipe_stage_reg and pipe_stage_entry.
package pipe_stage_reg_pkg;

   // addi x0, x0, 0 -- canonical RISC-V NOP, used as RESET_VALUE for insn-carrying stages
   localparam logic [31:0] NOP_INSN = 32'h00000013;

   // IF/ID: {pc, insn}
   localparam int IFID_W       = 64;
   localparam int IFID_INSN_LSB = 0;
   localparam int IFID_PC_LSB   = 32;

   // ID/EX: {ctrl[31:0], imm, rs2_val, rs1_val, pc}
   localparam int IDEX_W        = 160;
   localparam int IDEX_PC_LSB   = 0;
   localparam int IDEX_RS1_LSB  = 32;
   localparam int IDEX_RS2_LSB  = 64;
   localparam int IDEX_IMM_LSB  = 96;
   localparam int IDEX_CTRL_LSB = 128;

   // EX/MEM: {ctrl[7:0], rd[4:0], rs2_val, alu_res} padded to a byte boundary
   localparam int EXMEM_W        = 80;
   localparam int EXMEM_ALU_LSB  = 0;
   localparam int EXMEM_RS2_LSB  = 32;
   localparam int EXMEM_RD_LSB   = 64;
   localparam int EXMEM_CTRL_LSB = 69;

   // MEM/WB: {ctrl[3:0], rd[4:0], wb_val}
   localparam int MEMWB_W        = 41;
   localparam int MEMWB_VAL_LSB  = 0;
   localparam int MEMWB_RD_LSB   = 32;
   localparam int MEMWB_CTRL_LSB = 37;

   function automatic logic is_nop(input logic [31:0] insn);
      return insn == NOP_INSN;
   endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot: valid bit + WIDTH-bit payload with load / drop / clear controls.
// Latency: load visible one clk after the edge it is sampled on.
// Backpressure: none internally; the parent decides when to load or drop.
// Ports: clk, proc_reset (sync, active-high), clr (flush to RESET_VALUE),
//        load (capture d, set vld), drop (clear vld, keep payload), d, vld, q.
module pipe_stage_entry
   import pipe_stage_reg_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             proc_reset,
   input  logic             clr,
   input  logic             load,
   input  logic             drop,
   input  logic [WIDTH-1:0] d,
   output logic             vld,
   output logic [WIDTH-1:0] q
);

   // load wins over drop: a simultaneous drain + refill keeps the slot valid
   always_ff @(posedge clk) begin
      if (proc_reset || clr) begin
         vld <= 1'b0;
         q   <= RESET_VALUE;
      end else if (load) begin
         vld <= 1'b1;
         q   <= d;
      end else if (drop) begin
         vld <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, global stall and flush-to-NOP.
// Latency: 1 cycle (in_fire at edge N -> out_valid/out_data from edge N).
// Backpressure: default in_ready = ~out_valid | out_ready (combinational);
//   with PIPE_SKID_EN a skid slot makes in_ready = ~skid_valid (registered).
// Ports: clk, proc_reset, stall, flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count (entries held).
// Build option macro: PIPE_SKID_EN.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             proc_reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   logic             main_vld;
   logic [WIDTH-1:0] main_dat;
   logic             main_load;
   logic             main_drop;
   logic [WIDTH-1:0] main_d;
   logic             in_fire;
   logic             out_fire;

   // stall gates both ends identically, so neighbouring stages agree on every transfer
   assign in_fire  = in_valid & in_ready & ~stall;
   assign out_fire = main_vld & out_ready & ~stall;

   assign out_valid = main_vld;
   assign out_data  = main_dat;

`ifdef PIPE_SKID_EN
   logic             skid_vld;
   logic [WIDTH-1:0] skid_dat;
   logic             main_free;
   logic             skid_load;
   logic             skid_drop;

   assign in_ready = ~skid_vld;

   // main can take a new beat this edge if it is empty or draining (never under stall)
   assign main_free = (~main_vld & ~stall) | out_fire;

   // skid is older than any incoming beat, so it refills main first
   assign main_load = main_free & (skid_vld | in_fire);
   assign main_d    = skid_vld ? skid_dat : in_data;
   assign main_drop = out_fire;

   assign skid_load = in_fire & (~main_free | skid_vld);
   assign skid_drop = main_free & skid_vld;

   pipe_stage_entry #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
      .clk        (clk),
      .proc_reset (proc_reset),
      .clr        (flush),
      .load       (skid_load),
      .drop       (skid_drop),
      .d          (in_data),
      .vld        (skid_vld),
      .q          (skid_dat)
   );

   assign count = {1'b0, main_vld} + {1'b0, skid_vld};
`else
   assign in_ready  = ~main_vld | out_ready;
   assign main_load = in_fire;
   assign main_d    = in_data;
   assign main_drop = out_fire;
   assign count     = {1'b0, main_vld};
`endif

   pipe_stage_entry #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
      .clk        (clk),
      .proc_reset (proc_reset),
      .clr        (flush),
      .load       (main_load),
      .drop       (main_drop),
      .d          (main_d),
      .vld        (main_vld),
      .q          (main_dat)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: table of vectors common to both builds,
// then build-specific sequences for backpressure and flush.
module tb_pipe_stage_reg;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        proc_reset, stall, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [1:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(NOP)) dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .count      (count)
   );

   typedef struct {
      logic        rst, stl, fl, iv;
      logic [31:0] id;
      logic        ordy;
      logic        e_ov;
      logic [31:0] e_od;
      logic [1:0]  e_cnt;
      logic        e_ir;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic stl, logic fl, logic iv, logic [31:0] id,
                               logic ordy, logic e_ov, logic [31:0] e_od, logic [1:0] e_cnt,
                               logic e_ir);
      vec_t v;
      v.rst = rst; v.stl = stl; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt; v.e_ir = e_ir;
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drive inputs, take one rising edge, sample 1ns after it
   task automatic step(input logic rst, input logic stl, input logic fl, input logic iv,
                       input logic [31:0] id, input logic ordy);
      proc_reset = rst; stall = stl; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic ov, input logic [31:0] od,
                             input logic [1:0] cnt, input logic ir);
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
      check({tag, ".out_data"},  out_data, od);
      check({tag, ".count"},     {30'd0, count}, {30'd0, cnt});
      check({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, ir});
   endtask

   initial begin
      proc_reset = 1'b1; stall = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // reset held 2 cycles with a beat offered
      vecs.push_back(mk(1,0,0,1,32'hDEADBEEF,0, 0,NOP,0,1));
      vecs.push_back(mk(1,0,0,1,32'hDEADBEEF,0, 0,NOP,0,1));
      // streaming 0..7, one per cycle
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(0,0,0,1,k,1, 1,k,1,1));
      // drain: valid drops, payload keeps last value (not NOP)
      vecs.push_back(mk(0,0,0,0,32'h0,1, 0,32'h7,0,1));
      // stall: hold a beat for 5 cycles with a new beat offered
      vecs.push_back(mk(0,0,0,1,32'h55,1, 1,32'h55,1,1));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(0,1,0,1,32'h66,1, 1,32'h55,1,1));
      vecs.push_back(mk(0,0,0,1,32'h66,1, 1,32'h66,1,1));
      // simultaneous in/out fire: AA replaced by BB
      vecs.push_back(mk(0,0,0,1,32'hAA,1, 1,32'hAA,1,1));
      vecs.push_back(mk(0,0,0,1,32'hBB,1, 1,32'hBB,1,1));
      vecs.push_back(mk(0,0,0,0,32'h0,1, 0,32'hBB,0,1));
      // flush without stall beats a concurrent capture
      vecs.push_back(mk(0,0,0,1,32'h77,1, 1,32'h77,1,1));
      vecs.push_back(mk(0,0,1,1,32'h88,1, 0,NOP,0,1));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].stl, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         expect_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_cnt,
                    vecs[i].e_ir);
      end

`ifdef PIPE_SKID_EN
      // backpressure: A, B fill both slots; C is refused
      step(0,0,0,1,32'h11,0); expect_all("bp_a",    1, 32'h11, 1, 1);
      step(0,0,0,1,32'h22,0); expect_all("bp_b",    1, 32'h11, 2, 0);
      step(0,0,0,1,32'h33,0); expect_all("bp_full", 1, 32'h11, 2, 0);
      step(0,0,0,0,32'h0,1);  expect_all("bp_outA", 1, 32'h22, 1, 1);
      step(0,0,0,0,32'h0,1);  expect_all("bp_outB", 0, 32'h22, 0, 1);
      // flush under stall with both slots full and a beat offered
      step(0,0,0,1,32'h44,0); expect_all("fl_a",    1, 32'h44, 1, 1);
      step(0,0,0,1,32'h55,0); expect_all("fl_b",    1, 32'h44, 2, 0);
      step(0,1,1,1,32'h66,0); expect_all("flush",   0, NOP,    0, 1);
      step(0,0,0,0,32'h0,1);  expect_all("fl_post", 0, NOP,    0, 1);
`else
      // backpressure: one slot, second beat refused while out_ready=0
      step(0,0,0,1,32'h11,0); expect_all("bp_a",    1, 32'h11, 1, 0);
      step(0,0,0,1,32'h22,0); expect_all("bp_full", 1, 32'h11, 1, 0);
      // in_ready follows out_ready combinationally
      out_ready = 1'b1;
      #1;
      check("ir_comb", {31'd0, in_ready}, 32'd1);
      // flush under stall with a beat held and a beat offered
      step(0,1,1,1,32'h66,1); expect_all("flush",   0, NOP, 0, 1);
      step(0,0,0,0,32'h0,1);  expect_all("fl_post", 0, NOP, 0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
